id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU in the MIPS CPU.
- Each cycle it captures one decoded instruction and its operands, and decodes opcode/funct into the 4-bit ALU control code.
- It selects and forwards operands, so the ALU receives ready-to-use ALUCon/DataA/DataB from registers.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- DW, 32, datapath width of operands and forwarded results.
- RW, 5, register-index width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ID holds a valid instruction.
- opcode  in  6  instruction[31:26].
- funct  in  6  instruction[5:0].
- shamt  in  5  instruction[10:6].
- imm16  in  16  instruction[15:0].
- rs_idx, rt_idx, rd_idx  in  RW  register indices.
- rs_data, rt_data  in  DW  register-file read data.
- fwd_a_valid, fwd_b_valid  in  1  forwarding source A (EX/MEM) / B (MEM/WB) writes a register.
- fwd_a_idx, fwd_b_idx  in  RW  destination index of each source.
- fwd_a_data, fwd_b_data  in  DW  result of each source.
- stall  in  1  hold all outputs.
- flush  in  1  replace next captured entry with a bubble.
- alu_con  out  4  to ALU ALUCon.
- data_a, data_b  out  DW  to ALU DataA/DataB.
- dest_idx  out  RW  write-back register index.
- reg_write  out  1  instruction writes a register.
- mem_read, mem_write  out  1  load/store flags for MEM stage.
- store_data  out  DW  forwarded rt value for sw.
- out_valid  out  1  entry is a real instruction.
- illegal  out  1  captured opcode/funct not supported.

Behaviour:
- Reset value is used for unknown/bubble entries: alu_con=0010 (add); all other outputs 0.
- Reset is asynchronous; asserting it mid-operation discards the current entry.
- Latency is 1 cycle: inputs sampled at edge N appear at outputs after edge N. All outputs are registered, with no combinational input-to-output path.
- Priority per edge: flush > stall > capture.
  - flush=1: load the bubble (reset values).
  - stall=1, flush=0: hold every output unchanged.
  - Otherwise capture. If in_valid=0, capture a bubble.
- Forwarding, applied independently to rs and rt before capture:
  - If fwd_a_valid and fwd_a_idx==idx and idx!=0, use fwd_a_data.
  - Else if fwd_b_valid and fwd_b_idx==idx and idx!=0, use fwd_b_data.
  - Else use the register-file data.
  - Register 0 always reads 0.
- ALU codes: and 0000, or 0001, add 0010, mul 0011, nor 0100, div 0101, sub 0110, slt 0111, sll 1000, srl 1001.
- R-type (opcode 00), funct mapping:
  - 20/21 add, 22/23 sub, 24 and, 25 or, 27 nor, 2A slt: a=rs, b=rt.
  - 00 sll, 02 srl: a=rt, b=zero-extended shamt.
  - 18 mult, 1A div: a=rs, b=rt.
  - dest=rd; reg_write=1, except dest==0 forces reg_write=0.
- I-type: dest=rt, a=rs.
  - addi 08 / addiu 09: add, b=sign-ext imm.
  - andi 0C: and, b=zero-ext imm.
  - ori 0D: or, b=zero-ext imm.
  - slti 0A: slt, b=sign-ext imm.
  - lw 23: add, b=sign-ext imm, mem_read=1.
  - sw 2B: add, b=sign-ext imm, mem_write=1, reg_write=0, store_data=forwarded rt.
  - beq 04: sub, a=rs, b=rt, reg_write=0.
- Any other opcode/funct: illegal=1, out_valid=1, alu_con=0010, reg_write=mem_read=mem_write=0, data_a/data_b=0.
- Sign extension replicates imm16[15] to DW bits; zero extension pads with 0.

Decomposition:
- Shared package alu_pkg holds:
  - ALU code constants (ALU_AND..ALU_SRL).
  - Opcode/funct constants.
  - Bubble reset values.
- ALU consumes the same ALU code constants.
- One combinational sub-module, alu_ctrl_decode (opcode, funct → alu_con, operand-select, control flags, illegal).
- Forwarding muxes and the register remain in id_ex_stage.

Test Plan:
- Reset low then high, no stimulus → alu_con=0010, all other outputs 0, out_valid=0.
- add rs=3(0x5), rt=4(0x7), rd=8, no forwarding → next cycle alu_con=0010, a=5, b=7, dest=8, reg_write=1.
- addi imm=0xFFFF, rs=1(0x10) → b=0xFFFFFFFF, alu_con=0010; andi same imm → b=0x0000FFFF, alu_con=0000.
- Forwarding on rs=5: fwd_a idx5=0xAA and fwd_b idx5=0xBB → a=0xAA. Repeat with fwd_a_valid=0 → a=0xBB. Repeat with rs=0 and both sources idx0 → a=0.
- Capture sll shamt=4, then stall=1 for 3 cycles with new inputs → outputs hold alu_con=1000, b=4. Then assert flush and stall together → bubble, out_valid=0.
- opcode 3F → illegal=1, reg_write=0, alu_con=0010. sw → mem_write=1, reg_write=0, store_data=forwarded rt. Assert rst_n low mid-stream → outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control codes, MIPS opcode/funct values and ID/EX bubble values.
package alu_pkg;

  localparam int unsigned ALU_CON_W = 4;
  localparam int unsigned OPCODE_W  = 6;
  localparam int unsigned FUNCT_W   = 6;

  // ALU control codes, also consumed by the ALU
  localparam logic [ALU_CON_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CON_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CON_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CON_W-1:0] ALU_MUL = 4'b0011;
  localparam logic [ALU_CON_W-1:0] ALU_NOR = 4'b0100;
  localparam logic [ALU_CON_W-1:0] ALU_DIV = 4'b0101;
  localparam logic [ALU_CON_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_CON_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_CON_W-1:0] ALU_SLL = 4'b1000;
  localparam logic [ALU_CON_W-1:0] ALU_SRL = 4'b1001;

  // Opcodes
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [FUNCT_W-1:0] F_SLL  = 6'h00;
  localparam logic [FUNCT_W-1:0] F_SRL  = 6'h02;
  localparam logic [FUNCT_W-1:0] F_MULT = 6'h18;
  localparam logic [FUNCT_W-1:0] F_DIV  = 6'h1A;
  localparam logic [FUNCT_W-1:0] F_ADD  = 6'h20;
  localparam logic [FUNCT_W-1:0] F_ADDU = 6'h21;
  localparam logic [FUNCT_W-1:0] F_SUB  = 6'h22;
  localparam logic [FUNCT_W-1:0] F_SUBU = 6'h23;
  localparam logic [FUNCT_W-1:0] F_AND  = 6'h24;
  localparam logic [FUNCT_W-1:0] F_OR   = 6'h25;
  localparam logic [FUNCT_W-1:0] F_NOR  = 6'h27;
  localparam logic [FUNCT_W-1:0] F_SLT  = 6'h2A;

  // Bubble / reset entry: add code, everything else zero
  localparam logic [ALU_CON_W-1:0] BUBBLE_ALU_CON = ALU_ADD;

  // Operand selects produced by the decoder
  typedef enum logic {
    ASEL_RS = 1'b0,
    ASEL_RT = 1'b1
  } asel_e;

  typedef enum logic [1:0] {
    BSEL_RT    = 2'd0,
    BSEL_SHAMT = 2'd1,
    BSEL_SEXT  = 2'd2,
    BSEL_ZEXT  = 2'd3
  } bsel_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct decoder: ALU code, operand selects, control flags.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [FUNCT_W-1:0]   funct,
  output logic [ALU_CON_W-1:0] alu_con,
  output asel_e                a_sel,
  output bsel_e                b_sel,
  output logic                 dest_rd,
  output logic                 reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 store_en,
  output logic                 illegal
);

  // Decode table; unsupported encodings fall through to illegal
  always_comb begin
    alu_con   = BUBBLE_ALU_CON;
    a_sel     = ASEL_RS;
    b_sel     = BSEL_RT;
    dest_rd   = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    store_en  = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dest_rd   = 1'b1;
        reg_write = 1'b1;
        case (funct)
          F_ADD, F_ADDU: alu_con = ALU_ADD;
          F_SUB, F_SUBU: alu_con = ALU_SUB;
          F_AND:         alu_con = ALU_AND;
          F_OR:          alu_con = ALU_OR;
          F_NOR:         alu_con = ALU_NOR;
          F_SLT:         alu_con = ALU_SLT;
          F_MULT:        alu_con = ALU_MUL;
          F_DIV:         alu_con = ALU_DIV;
          F_SLL: begin
            alu_con = ALU_SLL;
            a_sel   = ASEL_RT;
            b_sel   = BSEL_SHAMT;
          end
          F_SRL: begin
            alu_con = ALU_SRL;
            a_sel   = ASEL_RT;
            b_sel   = BSEL_SHAMT;
          end
          default: begin
            dest_rd   = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        b_sel     = BSEL_SEXT;
        reg_write = 1'b1;
      end
      OP_ANDI: begin
        alu_con   = ALU_AND;
        b_sel     = BSEL_ZEXT;
        reg_write = 1'b1;
      end
      OP_ORI: begin
        alu_con   = ALU_OR;
        b_sel     = BSEL_ZEXT;
        reg_write = 1'b1;
      end
      OP_SLTI: begin
        alu_con   = ALU_SLT;
        b_sel     = BSEL_SEXT;
        reg_write = 1'b1;
      end
      OP_LW: begin
        b_sel     = BSEL_SEXT;
        reg_write = 1'b1;
        mem_read  = 1'b1;
      end
      OP_SW: begin
        b_sel     = BSEL_SEXT;
        mem_write = 1'b1;
        store_en  = 1'b1;
      end
      OP_BEQ: begin
        alu_con = ALU_SUB;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand forwarding, ALU-control decode, stall/flush.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic [4:0]           shamt,
  input  logic [15:0]          imm16,
  input  logic [RW-1:0]        rs_idx,
  input  logic [RW-1:0]        rt_idx,
  input  logic [RW-1:0]        rd_idx,
  input  logic [DW-1:0]        rs_data,
  input  logic [DW-1:0]        rt_data,
  input  logic                 fwd_a_valid,
  input  logic                 fwd_b_valid,
  input  logic [RW-1:0]        fwd_a_idx,
  input  logic [RW-1:0]        fwd_b_idx,
  input  logic [DW-1:0]        fwd_a_data,
  input  logic [DW-1:0]        fwd_b_data,
  input  logic                 stall,
  input  logic                 flush,
  output logic [ALU_CON_W-1:0] alu_con,
  output logic [DW-1:0]        data_a,
  output logic [DW-1:0]        data_b,
  output logic [RW-1:0]        dest_idx,
  output logic                 reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [DW-1:0]        store_data,
  output logic                 out_valid,
  output logic                 illegal
);

  logic [ALU_CON_W-1:0] dec_alu_con;
  asel_e                dec_a_sel;
  bsel_e                dec_b_sel;
  logic                 dec_dest_rd;
  logic                 dec_reg_write;
  logic                 dec_mem_read;
  logic                 dec_mem_write;
  logic                 dec_store_en;
  logic                 dec_illegal;

  logic [DW-1:0]        op_rs;
  logic [DW-1:0]        op_rt;

  logic [ALU_CON_W-1:0] nxt_alu_con;
  logic [DW-1:0]        nxt_data_a;
  logic [DW-1:0]        nxt_data_b;
  logic [RW-1:0]        nxt_dest_idx;
  logic                 nxt_reg_write;
  logic                 nxt_mem_read;
  logic                 nxt_mem_write;
  logic [DW-1:0]        nxt_store_data;
  logic                 nxt_out_valid;
  logic                 nxt_illegal;

  alu_ctrl_decode u_dec (
    .opcode    (opcode),
    .funct     (funct),
    .alu_con   (dec_alu_con),
    .a_sel     (dec_a_sel),
    .b_sel     (dec_b_sel),
    .dest_rd   (dec_dest_rd),
    .reg_write (dec_reg_write),
    .mem_read  (dec_mem_read),
    .mem_write (dec_mem_write),
    .store_en  (dec_store_en),
    .illegal   (dec_illegal)
  );

  // EX/MEM source wins over MEM/WB; register 0 is hardwired to zero
  function automatic logic [DW-1:0] fwd_sel(input logic [RW-1:0] idx,
                                            input logic [DW-1:0] rf_data);
    if (idx == '0)                               return '0;
    else if (fwd_a_valid && (fwd_a_idx == idx))  return fwd_a_data;
    else if (fwd_b_valid && (fwd_b_idx == idx))  return fwd_b_data;
    else                                         return rf_data;
  endfunction

  // Forwarded source operands
  always_comb begin
    op_rs = fwd_sel(rs_idx, rs_data);
    op_rt = fwd_sel(rt_idx, rt_data);
  end

  // Next entry to capture; invalid or illegal instructions zero the datapath
  always_comb begin
    nxt_alu_con    = BUBBLE_ALU_CON;
    nxt_data_a     = '0;
    nxt_data_b     = '0;
    nxt_dest_idx   = '0;
    nxt_reg_write  = 1'b0;
    nxt_mem_read   = 1'b0;
    nxt_mem_write  = 1'b0;
    nxt_store_data = '0;
    nxt_out_valid  = 1'b0;
    nxt_illegal    = 1'b0;
    if (in_valid) begin
      nxt_out_valid = 1'b1;
      nxt_illegal   = dec_illegal;
      if (!dec_illegal) begin
        nxt_alu_con   = dec_alu_con;
        nxt_data_a    = (dec_a_sel == ASEL_RT) ? op_rt : op_rs;
        case (dec_b_sel)
          BSEL_SHAMT: nxt_data_b = {{(DW-5){1'b0}}, shamt};
          BSEL_SEXT:  nxt_data_b = {{(DW-16){imm16[15]}}, imm16};
          BSEL_ZEXT:  nxt_data_b = {{(DW-16){1'b0}}, imm16};
          default:    nxt_data_b = op_rt;
        endcase
        nxt_dest_idx   = dec_dest_rd ? rd_idx : rt_idx;
        nxt_reg_write  = dec_reg_write && !(dec_dest_rd && (rd_idx == '0));
        nxt_mem_read   = dec_mem_read;
        nxt_mem_write  = dec_mem_write;
        nxt_store_data = dec_store_en ? op_rt : '0;
      end
    end
  end

  // Pipeline register: flush beats stall beats capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_con    <= BUBBLE_ALU_CON;
      data_a     <= '0;
      data_b     <= '0;
      dest_idx   <= '0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      store_data <= '0;
      out_valid  <= 1'b0;
      illegal    <= 1'b0;
    end else if (flush) begin
      alu_con    <= BUBBLE_ALU_CON;
      data_a     <= '0;
      data_b     <= '0;
      dest_idx   <= '0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      store_data <= '0;
      out_valid  <= 1'b0;
      illegal    <= 1'b0;
    end else if (!stall) begin
      alu_con    <= nxt_alu_con;
      data_a     <= nxt_data_a;
      data_b     <= nxt_data_b;
      dest_idx   <= nxt_dest_idx;
      reg_write  <= nxt_reg_write;
      mem_read   <= nxt_mem_read;
      mem_write  <= nxt_mem_write;
      store_data <= nxt_store_data;
      out_valid  <= nxt_out_valid;
      illegal    <= nxt_illegal;
    end
  end

endmodule
